// File: rtl/pe_traceback.sv
// pe_traceback: captures per-step lane pointers from the PE array, then walks
// the pointer matrix back from the end cell and streams alignment ops.
// Optional: TB_EDIT_COUNT_EN adds the edit_cnt output (UP/LEFT op count).
module pe_traceback #(
  parameter int B  = 4,
  parameter int L  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [CW-1:0] in_ctr,
  input  logic [3*B-1:0] in_ptr,
  output logic          in_ready,
  output logic          tb_valid,
  input  logic          tb_ready,
  output logic [1:0]    tb_op,
  output logic          tb_last,
  output logic          done,
  output logic          err
`ifdef TB_EDIT_COUNT_EN
  ,
  output logic [CW-1:0] edit_cnt
`endif
);

  localparam int NSTEP = 2*L - 1;
  localparam int SW    = $clog2(NSTEP);
  localparam int LW    = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

  localparam logic [2:0] P_DIAG = 3'b001;
  localparam logic [2:0] P_UP   = 3'b010;
  localparam logic [2:0] P_LEFT = 3'b011;

  typedef enum logic [1:0] {S_CAPTURE, S_WALK, S_DONE} state_t;

  state_t state;
  logic [3*B-1:0] mem [NSTEP];

  // cursor carries one extra sign bit so stepping past 0 is detectable
  logic signed [SW:0] cur_step, nxt_step;
  logic signed [LW:0] cur_lane, nxt_lane;
  logic [3*B-1:0] row;
  logic [2:0]     p;
  logic           code_ok;
  logic [1:0]     op_dec;
  logic           last_c;
  logic           cap_ok;

`ifndef TB_EDIT_COUNT_EN
  logic [CW-1:0] edit_cnt;
`endif

  assign cap_ok = (state == S_CAPTURE) && in_valid && (in_ctr <= LAST_STEP);

  // pointer storage: registered write during capture, never reset
  always_ff @(posedge clk) begin
    if (cap_ok) mem[in_ctr[SW-1:0]] <= in_ptr;
  end

  // decode the pointer under the cursor and compute where it leads
  always_comb begin
    row      = mem[cur_step[SW-1:0]];
    p        = row[3*int'(cur_lane[LW-1:0]) +: 3];
    code_ok  = 1'b1;
    op_dec   = 2'b00;
    nxt_step = cur_step - (SW+1)'(1);
    nxt_lane = cur_lane;
    case (p)
      P_DIAG: begin
        op_dec   = 2'b00;
        nxt_step = cur_step - (SW+1)'(2);
      end
      P_UP: begin
        op_dec   = 2'b01;
        nxt_lane = cur_lane - (LW+1)'(1);
      end
      P_LEFT: op_dec = 2'b10;
      default: code_ok = 1'b0;
    endcase
    last_c = nxt_step[SW] | nxt_lane[LW];
  end

  assign in_ready = (state == S_CAPTURE);
  assign tb_valid = (state == S_WALK) && code_ok;
  assign tb_op    = tb_valid ? op_dec : 2'b00;
  assign tb_last  = tb_valid && last_c;
  assign done     = (state == S_DONE);

  // control FSM: capture -> walk -> done -> capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_CAPTURE;
      cur_step <= '0;
      cur_lane <= '0;
      err      <= 1'b0;
      edit_cnt <= '0;
    end else begin
      case (state)
        S_CAPTURE: begin
          if (in_valid) begin
            if (in_ctr > LAST_STEP) begin
              err <= 1'b1;
            end else begin
              if (in_ctr == '0) err <= 1'b0;
              if (in_ctr == LAST_STEP) begin
                state    <= S_WALK;
                cur_step <= (SW+1)'(NSTEP - 1);
                cur_lane <= (LW+1)'(B - 1);
                edit_cnt <= '0;
              end
            end
          end
        end
        S_WALK: begin
          if (!code_ok) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else if (tb_ready) begin
            cur_step <= nxt_step;
            cur_lane <= nxt_lane;
            if (op_dec != 2'b00) edit_cnt <= edit_cnt + CW'(1);
            if (last_c) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_CAPTURE;
        default: state <= S_CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_traceback.sv
// Randomized scoreboard bench for pe_traceback.
module tb_pe_traceback;
  localparam int B = 4, L = 8, CW = 8;
  localparam int NSTEP = 2*L - 1;

  logic clk = 0, rst = 1;
  logic in_valid = 0;
  logic [CW-1:0] in_ctr = '0;
  logic [3*B-1:0] in_ptr = '0;
  logic in_ready, tb_valid, tb_ready, tb_last, done, err;
  logic [1:0] tb_op;
`ifdef TB_EDIT_COUNT_EN
  logic [CW-1:0] edit_cnt;
`endif

  pe_traceback #(.B(B), .L(L), .CW(CW)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ctr(in_ctr), .in_ptr(in_ptr),
    .in_ready(in_ready), .tb_valid(tb_valid), .tb_ready(tb_ready), .tb_op(tb_op),
    .tb_last(tb_last), .done(done), .err(err)
`ifdef TB_EDIT_COUNT_EN
    , .edit_cnt(edit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total = 0;
  logic [2:0] rm [NSTEP][B];
  logic [2:0] exp_q [$];        // {op, last}
  int rdy_mode = 0;
  int cyc = 0, last_hs_cyc = 0, hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ready driver: 0 always, 1 pattern 1,0,0,1, 2 random
  initial begin
    int ph = 0;
    tb_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tb_ready = 1;
        1: tb_ready = (ph == 0 || ph == 3);
        default: tb_ready = $urandom_range(0, 1) == 1;
      endcase
      ph = (ph + 1) % 4;
    end
  end

  // monitor: pops expected ops on handshake, checks stall stability
  initial begin
    bit stalled = 0;
    logic [1:0] s_op;
    logic s_last;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) stalled = 0;
      else begin
        if (stalled) begin
          chk("stall_valid", tb_valid, 1);
          chk("stall_op_last", {tb_op, tb_last}, {s_op, s_last});
        end
        stalled = 0;
        if (tb_valid && tb_ready) begin
          if (exp_q.size() == 0) chk("unexpected_op", 1, 0);
          else chk("op_last", {tb_op, tb_last}, exp_q.pop_front());
          last_hs_cyc = cyc;
          hs_cnt++;
        end else if (tb_valid) begin
          stalled = 1; s_op = tb_op; s_last = tb_last;
        end
      end
    end
  end

  function automatic logic [3*B-1:0] word(input int s);
    logic [3*B-1:0] w;
    for (int k = 0; k < B; k++) w[3*k +: 3] = rm[s][k];
    return w;
  endfunction

  // kind: 0 diag, 1 up, 2 left, 3 random valid, 4 random with rare invalid
  task automatic fill(input int kind);
    for (int s = 0; s < NSTEP; s++)
      for (int k = 0; k < B; k++)
        case (kind)
          0: rm[s][k] = 3'd1;
          1: rm[s][k] = 3'd2;
          2: rm[s][k] = 3'd3;
          3: rm[s][k] = 3'($urandom_range(1, 3));
          default: rm[s][k] = ($urandom_range(0, 19) == 0) ? 3'd0 : 3'($urandom_range(1, 3));
        endcase
  endtask

  // reference walk: pushes expected ops, returns error/op/edit counts
  task automatic model(output bit m_err, output int nops, output int edits);
    int s = NSTEP - 1, ln = B - 1;
    m_err = 0; nops = 0; edits = 0;
    while (1) begin
      logic [2:0] c = rm[s][ln];
      int ns, nl;
      logic [1:0] op;
      if (c == 1) begin op = 2'b00; ns = s - 2; nl = ln; end
      else if (c == 2) begin op = 2'b01; ns = s - 1; nl = ln - 1; end
      else if (c == 3) begin op = 2'b10; ns = s - 1; nl = ln; end
      else begin m_err = 1; break; end
      exp_q.push_back({op, (ns < 0 || nl < 0)});
      nops++;
      if (op != 0) edits++;
      if (ns < 0 || nl < 0) break;
      s = ns; ln = nl;
    end
  endtask

  task automatic capture(input int s, input logic [3*B-1:0] w);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1 in_valid = 1; in_ctr = CW'(s); in_ptr = w;
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic do_run(input string tag, input bit bad_mid);
    bit m_err; int nops, edits, n;
    exp_q.delete();
    model(m_err, nops, edits);
    for (int s = 0; s < NSTEP; s++) begin
      if (bad_mid && s == NSTEP - 1) begin
        capture(20, '0);
        @(negedge clk); #1;
        chk({tag, "_bad_err"}, err, 1);
        chk({tag, "_bad_ready"}, {in_ready, tb_valid}, 2'b10);
      end
      capture(s, word(s));
    end
    @(negedge clk); #1;
    chk({tag, "_first_valid"}, tb_valid, !(rm[NSTEP-1][B-1] inside {3'd1, 3'd2, 3'd3}) ? 0 : 1);
    n = 0;
    while (!done && n < 300) begin @(negedge clk); #1; n++; end
    if (!done) chk({tag, "_done_timeout"}, 0, 1);
    else begin
      chk({tag, "_err"}, err, m_err | bad_mid);
      chk({tag, "_ops_left"}, exp_q.size(), 0);
      if (!m_err) chk({tag, "_done_lat"}, cyc - last_hs_cyc, 1);
`ifdef TB_EDIT_COUNT_EN
      chk({tag, "_edit_cnt"}, edit_cnt, edits);
`endif
      @(negedge clk); #1;
      chk({tag, "_done_pulse"}, {done, in_ready}, 2'b01);
    end
  endtask

  initial begin
    int h0;
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", {in_ready, tb_valid, tb_op, tb_last, done, err}, 7'b1000000);
    @(posedge clk); #1 rst = 0;
    @(negedge clk); #1 chk("post_reset", {in_ready, tb_valid, done, err}, 4'b1000);

    rdy_mode = 0; fill(0); do_run("diag", 0);
    fill(2); do_run("left", 0);
    fill(1); do_run("up", 0);
    rdy_mode = 1; fill(0); do_run("diag_stall", 0);
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) begin fill(3); do_run("rand", 0); end
    for (int i = 0; i < 6; i++) begin fill(4); do_run("rand_inv", 0); end

    // invalid end cell
    rdy_mode = 0; fill(0); rm[NSTEP-1][B-1] = 3'd0; do_run("inv_end", 0);
    capture(0, word(0));
    @(negedge clk); #1 chk("err_clear", err, 0);

    // out-of-range write dropped (would otherwise corrupt step 4)
    fill(2); do_run("oor", 1);

    // reset during walk after 3 ops
    fill(0); exp_q.delete();
    for (int s = 0; s < NSTEP; s++) capture(s, word(s));
    for (int s = 0; s < NSTEP; s++) exp_q.push_back({2'b00, s == 7});
    h0 = hs_cnt;
    for (int n = 0; n < 50 && hs_cnt - h0 < 3; n++) begin @(negedge clk); #1; end
    chk("three_ops", hs_cnt - h0, 3);
    @(posedge clk); #2 rst = 1;
    #1 chk("rst_async_valid", {tb_valid, done}, 2'b00);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); #1 chk("rst_release", {in_ready, tb_valid, err}, 3'b100);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
